// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int DEF_AW = 20;
    localparam int DEF_DW = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester handshakes plus memory-side bus of the arbiter
interface mem_arbiter_if #(
    parameter int AW = mem_arb_pkg::DEF_AW,
    parameter int DW = mem_arb_pkg::DEF_DW
);
    logic          a_req;
    logic [AW-1:0] a_addr;
    logic          a_we;
    logic [DW-1:0] a_wdata;
    logic          a_ack;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic [AW-1:0] b_addr;
    logic          b_we;
    logic [DW-1:0] b_wdata;
    logic          b_ack;
    logic [DW-1:0] b_rdata;

    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_out;
    logic          mem_wren;
    logic [DW-1:0] mem_data;
    logic          busy;

    modport slave (
        input  a_req, a_addr, a_we, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_addr, b_we, b_wdata,
        output b_ack, b_rdata,
        output mem_address, mem_out, mem_wren,
        input  mem_data,
        output busy
    );

    modport master (
        output a_req, a_addr, a_we, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_addr, b_we, b_wdata,
        input  b_ack, b_rdata,
        input  mem_address, mem_out, mem_wren,
        output mem_data,
        input  busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select; MEM_ARB_RR_EN selects round-robin,
// otherwise fixed B priority with an A starvation override.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
`ifdef MEM_ARB_RR_EN
    input  logic last_grant,
`else
    input  logic starve_full,
`endif
    output logic grant,
    output logic valid
);

    assign valid = a_req | b_req;

`ifdef MEM_ARB_RR_EN
    always_comb begin
        grant = b_req ? PORT_B : PORT_A;
        if (a_req && b_req) begin
            grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end
    end
`else
    always_comb begin
        grant = b_req ? PORT_B : PORT_A;
        if (a_req && b_req && starve_full) begin
            grant = PORT_A;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises two requesters onto one synchronous-read byte memory.
// Arbitration mode chosen by MEM_ARB_RR_EN (see mem_arb_pick).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int RD_LATENCY = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);

    state_t        state, state_n;
    logic [2:0]    lat, lat_n;
    logic          sel, sel_n;
    logic          we_q, we_n;
    logic [AW-1:0] addr_q, addr_n;
    logic [DW-1:0] wdata_q, wdata_n;
    logic          wren_q, wren_n;
    logic          a_ack_q, a_ack_n;
    logic          b_ack_q, b_ack_n;
    logic [DW-1:0] a_rdata_q, a_rdata_n;
    logic [DW-1:0] b_rdata_q, b_rdata_n;
    logic          pick_grant;
    logic          pick_valid;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_n;

    mem_arb_pick u_pick (
        .a_req      (bus.a_req),
        .b_req      (bus.b_req),
        .last_grant (last_q),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );
`else
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    logic [3:0] starve_q, starve_n;

    mem_arb_pick u_pick (
        .a_req       (bus.a_req),
        .b_req       (bus.b_req),
        .starve_full (starve_q == SMAX),
        .grant       (pick_grant),
        .valid       (pick_valid)
    );
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lat       <= 3'd0;
            sel       <= PORT_A;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wren_q    <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_q    <= PORT_A;
`else
            starve_q  <= 4'd0;
`endif
        end else begin
            state     <= state_n;
            lat       <= lat_n;
            sel       <= sel_n;
            we_q      <= we_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            wren_q    <= wren_n;
            a_ack_q   <= a_ack_n;
            b_ack_q   <= b_ack_n;
            a_rdata_q <= a_rdata_n;
            b_rdata_q <= b_rdata_n;
`ifdef MEM_ARB_RR_EN
            last_q    <= last_n;
`else
            starve_q  <= starve_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        lat_n     = lat;
        sel_n     = sel;
        we_n      = we_q;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        wren_n    = wren_q;
        a_ack_n   = a_ack_q;
        b_ack_n   = b_ack_q;
        a_rdata_n = a_rdata_q;
        b_rdata_n = b_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_n    = last_q;
`else
        starve_n  = starve_q;
`endif
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    sel_n   = pick_grant;
                    addr_n  = (pick_grant == PORT_B) ? bus.b_addr  : bus.a_addr;
                    wdata_n = (pick_grant == PORT_B) ? bus.b_wdata : bus.a_wdata;
                    we_n    = (pick_grant == PORT_B) ? bus.b_we    : bus.a_we;
                    wren_n  = we_n;
                    lat_n   = we_n ? 3'd0 : 3'(RD_LATENCY);
                    state_n = WAIT;
`ifdef MEM_ARB_RR_EN
                    last_n  = pick_grant;
`else
                    if (pick_grant == PORT_A) begin
                        starve_n = 4'd0;
                    end else if (bus.a_req && starve_q != SMAX) begin
                        starve_n = starve_q + 4'd1;
                    end
`endif
                end
            end
            WAIT: begin
                wren_n = 1'b0;
                if (lat == 3'd0) begin
                    if (sel == PORT_B) begin
                        b_ack_n = 1'b1;
                        if (!we_q) b_rdata_n = bus.mem_data;
                    end else begin
                        a_ack_n = 1'b1;
                        if (!we_q) a_rdata_n = bus.mem_data;
                    end
                    state_n = DONE;
                end else begin
                    lat_n = lat - 3'd1;
                end
            end
            DONE: begin
                a_ack_n = 1'b0;
                b_ack_n = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.mem_address = addr_q;
    assign bus.mem_out     = wdata_q;
    assign bus.mem_wren    = wren_q;
    assign bus.a_ack       = a_ack_q;
    assign bus.b_ack       = b_ack_q;
    assign bus.a_rdata     = a_rdata_q;
    assign bus.b_rdata     = b_rdata_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter (RD_LATENCY 1 and 3 instances,
// arbitration expectations follow MEM_ARB_RR_EN).
module tb_mem_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mem_arbiter_if ifc1 ();
    mem_arbiter_if ifc2 ();

    mem_arbiter #(.RD_LATENCY(1), .STARVE_MAX(4)) u_dut1 (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (ifc1)
    );

    mem_arbiter #(.RD_LATENCY(3), .STARVE_MAX(4)) u_dut2 (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (ifc2)
    );

    logic [7:0] mem1 [0:1048575];
    logic [7:0] mem2 [0:1048575];
    logic [7:0] p1;
    logic [7:0] p2 [0:2];

    always @(posedge clk) begin
        if (ifc1.mem_wren) mem1[ifc1.mem_address] <= ifc1.mem_out;
        p1 <= mem1[ifc1.mem_address];
    end
    assign ifc1.mem_data = p1;

    always @(posedge clk) begin
        if (ifc2.mem_wren) mem2[ifc2.mem_address] <= ifc2.mem_out;
        p2[0] <= mem2[ifc2.mem_address];
        p2[1] <= p2[0];
        p2[2] <= p2[1];
    end
    assign ifc2.mem_data = p2[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int d, input bit p, input bit r, input bit we,
                           input logic [19:0] ad, input logic [7:0] wd);
        if (d == 1 && !p) begin
            ifc1.a_req = r; ifc1.a_we = we; ifc1.a_addr = ad; ifc1.a_wdata = wd;
        end else if (d == 1) begin
            ifc1.b_req = r; ifc1.b_we = we; ifc1.b_addr = ad; ifc1.b_wdata = wd;
        end else if (!p) begin
            ifc2.a_req = r; ifc2.a_we = we; ifc2.a_addr = ad; ifc2.a_wdata = wd;
        end else begin
            ifc2.b_req = r; ifc2.b_we = we; ifc2.b_addr = ad; ifc2.b_wdata = wd;
        end
    endtask

    function automatic bit get_ack(input int d, input bit p);
        if (d == 1) return p ? ifc1.b_ack : ifc1.a_ack;
        return p ? ifc2.b_ack : ifc2.a_ack;
    endfunction

    function automatic logic [7:0] get_rd(input int d, input bit p);
        if (d == 1) return p ? ifc1.b_rdata : ifc1.a_rdata;
        return p ? ifc2.b_rdata : ifc2.a_rdata;
    endfunction

    // Lat counts rising edges from the sampling edge to the edge that raised ack.
    task automatic acc(input int d, input bit p, input bit we, input logic [19:0] ad,
                       input logic [7:0] wd, output logic [7:0] rd, output int lat, output int wr);
        bit got;
        got = 0; lat = -1; wr = 0; rd = 8'h00;
        set_req(d, p, 1'b1, we, ad, wd);
        for (int n = 1; n <= 50 && !got; n++) begin
            @(negedge clk);
            if ((d == 1) ? ifc1.mem_wren : ifc2.mem_wren) wr++;
            if (get_ack(d, p)) begin
                got = 1;
                lat = n - 1;
                rd = get_rd(d, p);
            end
        end
        set_req(d, p, 1'b0, 1'b0, 20'h0, 8'h0);
        if (!got) chk("acc_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    logic [7:0] rd;
    int         lat;
    int         wr;
    int         a_lat, b_lat, first, g, seen;
    logic       grants [0:9];
    logic       exp_g  [0:9];

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_req(1, 0, 0, 0, 20'h0, 8'h0);
        set_req(1, 1, 0, 0, 20'h0, 8'h0);
        set_req(2, 0, 0, 0, 20'h0, 8'h0);
        set_req(2, 1, 0, 0, 20'h0, 8'h0);
        repeat (2) @(negedge clk);

        chk("rst_busy",   32'(ifc1.busy),        32'd0);
        chk("rst_wren",   32'(ifc1.mem_wren),    32'd0);
        chk("rst_a_ack",  32'(ifc1.a_ack),       32'd0);
        chk("rst_b_ack",  32'(ifc1.b_ack),       32'd0);
        chk("rst_addr",   32'(ifc1.mem_address), 32'd0);
        chk("rst_out",    32'(ifc1.mem_out),     32'd0);
        chk("rst_a_rd",   32'(ifc1.a_rdata),     32'd0);
        chk("rst_b_rd",   32'(ifc2.b_rdata),     32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        acc(1, 0, 1'b1, 20'h08000, 8'h5A, rd, lat, wr);
        chk("a_wr_lat",  32'(lat), 32'd1);
        chk("a_wr_wren", 32'(wr),  32'd1);
        chk("a_wr_mem",  32'(mem1[20'h08000]), 32'h5A);

        acc(1, 0, 1'b0, 20'h08000, 8'h00, rd, lat, wr);
        chk("a_rd_lat",  32'(lat), 32'd2);
        chk("a_rd_data", 32'(rd),  32'h5A);
        chk("a_rd_wren", 32'(wr),  32'd0);

        acc(1, 1, 1'b1, 20'h00010, 8'h33, rd, lat, wr);
        chk("b_wr_lat",  32'(lat), 32'd1);
        chk("b_wr_mem",  32'(mem1[20'h00010]), 32'h33);

        // Contention: B wins first, A follows four cycles later.
        set_req(1, 0, 1'b1, 1'b0, 20'h08000, 8'h00);
        set_req(1, 1, 1'b1, 1'b0, 20'h00010, 8'h00);
        a_lat = -1; b_lat = -1; first = -1;
        for (int n = 1; n <= 40 && (a_lat < 0 || b_lat < 0); n++) begin
            @(negedge clk);
            if (ifc1.a_ack && ifc1.b_ack) chk("cont_overlap", 32'd1, 32'd0);
            if (ifc1.b_ack) begin
                b_lat = n - 1;
                if (first < 0) first = 1;
                chk("cont_b_data", 32'(ifc1.b_rdata), 32'h33);
                set_req(1, 1, 1'b0, 1'b0, 20'h0, 8'h0);
            end
            if (ifc1.a_ack) begin
                a_lat = n - 1;
                if (first < 0) first = 0;
                chk("cont_a_data", 32'(ifc1.a_rdata), 32'h5A);
                set_req(1, 0, 1'b0, 1'b0, 20'h0, 8'h0);
            end
        end
        chk("cont_first", 32'(first), 32'd1);
        chk("cont_b_lat", 32'(b_lat), 32'd2);
        chk("cont_a_lat", 32'(a_lat), 32'd6);
        @(negedge clk);

        // Both requesters held high continuously; log the grant sequence.
`ifdef MEM_ARB_RR_EN
        for (int i = 0; i < 10; i++) exp_g[i] = (i % 2 == 0);
`else
        for (int i = 0; i < 10; i++) exp_g[i] = !(i == 4 || i == 9);
`endif
        set_req(1, 0, 1'b1, 1'b0, 20'h08000, 8'h00);
        set_req(1, 1, 1'b1, 1'b0, 20'h00010, 8'h00);
        g = 0;
        for (int n = 0; n < 300 && g < 10; n++) begin
            @(negedge clk);
            if (ifc1.a_ack && ifc1.b_ack) begin
                chk("arb_overlap", 32'd1, 32'd0);
            end else if (ifc1.a_ack) begin
                grants[g] = 1'b0;
                g = g + 1;
            end else if (ifc1.b_ack) begin
                grants[g] = 1'b1;
                g = g + 1;
            end
        end
        set_req(1, 0, 1'b0, 1'b0, 20'h0, 8'h0);
        set_req(1, 1, 1'b0, 1'b0, 20'h0, 8'h0);
        repeat (3) @(negedge clk);
        chk("arb_count", 32'(g), 32'd10);
        for (int i = 0; i < g; i++) begin
            chk($sformatf("arb_grant%0d", i), 32'(grants[i]), 32'(exp_g[i]));
        end

        // Reset asserted while a read waits on memory latency.
        set_req(1, 0, 1'b1, 1'b0, 20'h08000, 8'h00);
        @(negedge clk);
        chk("mid_busy_pre", 32'(ifc1.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy",  32'(ifc1.busy),        32'd0);
        chk("mid_wren",  32'(ifc1.mem_wren),    32'd0);
        chk("mid_a_ack", 32'(ifc1.a_ack),       32'd0);
        chk("mid_b_ack", 32'(ifc1.b_ack),       32'd0);
        chk("mid_addr",  32'(ifc1.mem_address), 32'd0);
        set_req(1, 0, 1'b0, 1'b0, 20'h0, 8'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (ifc1.a_ack) seen = 1;
        end
        chk("mid_no_ack", 32'(seen), 32'd0);
        acc(1, 0, 1'b0, 20'h08000, 8'h00, rd, lat, wr);
        chk("post_rst_lat",  32'(lat), 32'd2);
        chk("post_rst_data", 32'(rd),  32'h5A);

        // RD_LATENCY=3 instance at the top address.
        acc(2, 0, 1'b1, 20'hFFFFF, 8'hC3, rd, lat, wr);
        chk("l3_wr_lat",  32'(lat), 32'd1);
        chk("l3_wr_wren", 32'(wr),  32'd1);
        acc(2, 0, 1'b0, 20'hFFFFF, 8'h00, rd, lat, wr);
        chk("l3_rd_lat",  32'(lat), 32'd4);
        chk("l3_rd_data", 32'(rd),  32'hC3);
        chk("l3_addr",    32'(ifc2.mem_address), 32'hFFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port, byte-wide, synchronous-read main memory (1 MB, 20-bit address) between two requesters.
- Port A is the CPU core; port B is a secondary master (video scan-out / DMA).
- Sits between the requesters and the memory array.
- Provides a req/ack handshake per port, serialises accesses and hides the memory read latency.

Parameters:
- AW, 20, address width (bytes)
- DW, 8, data width
- RD_LATENCY, 1, clocks from address/wren visible at memory to read data valid on mem_data (range 1..7)
- STARVE_MAX, 4, consecutive lost arbitrations by A before A is forced to win (range 1..15)

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- a_req  in  1  A request; level, held until a_ack
- a_addr  in  AW  A byte address
- a_we  in  1  A write enable (1 = write, 0 = read)
- a_wdata  in  DW  A write data
- a_ack  out  1  A one-cycle completion pulse
- a_rdata  out  DW  A read data; valid with a_ack, held until next A read completes
- b_req, b_addr, b_we, b_wdata, b_ack, b_rdata  same widths and directions as the A signals, for port B
- mem_address  out  AW  memory address, registered
- mem_out  out  DW  memory write data, registered
- mem_wren  out  1  memory write strobe, registered, exactly one cycle per write
- mem_data  in  DW  memory read data; registered inside the memory
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, immediate on reset_n low):
  - state=IDLE
  - mem_wren=0, a_ack=b_ack=0
  - mem_address=0, mem_out=0, a_rdata=b_rdata=0
  - starve count=0, last-grant=A
  - A transaction in flight is aborted with no ack. A write already sampled by memory stands.
- States: IDLE -> WAIT -> DONE -> IDLE.
- IDLE:
  - If neither req is high: remain in IDLE, outputs unchanged.
  - If a req is high: select the winner (arbitration below) and latch its addr into mem_address and its wdata into mem_out.
  - mem_wren<=winner's we; latency counter <= (we ? 0 : RD_LATENCY); state<=WAIT.
- WAIT:
  - mem_wren<=0.
  - If counter==0: for a read, the winner's rdata<=mem_data; the winner's ack<=1; state<=DONE.
  - Else: counter decrements.
- DONE:
  - ack<=0; state<=IDLE.
  - req is ignored in DONE. The requester must drop or change req during its ack cycle.
- Latency (request sampled at edge N):
  - Write: ack visible after edge N+1.
  - Read: ack visible after edge N+1+RD_LATENCY.
  - Next arbitration happens at the first edge in IDLE, so back-to-back accesses are write 3 cycles, read 3+RD_LATENCY cycles.
- Arbitration (default fixed priority):
  - B beats A.
  - Each IDLE decision where a_req=1 and B wins increments the starve count, saturating at STARVE_MAX.
  - When the count == STARVE_MAX, A wins the next contested decision.
  - Any grant to A clears the count.
  - Only one port is ever granted per transaction; an uncontested port always wins.
- Request fields are sampled only in IDLE. Changes during WAIT/DONE have no effect on the current transaction.
- Address and data widths pass through unchanged; no wrap or modification of the address.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A contested decision goes to the port not granted last; uncontested grants still update last-grant. The starve counter and STARVE_MAX are unused (the counter is not instantiated).
- Undefined: fixed B priority with starvation guard, as above.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, WAIT, DONE}
  - port index constants PORT_A=0, PORT_B=1
  - default AW/DW localparams
- Sub-module mem_arb_pick:
  - Combinational winner select from a_req, b_req, starve count / last-grant.
  - Carries the MEM_ARB_RR_EN variant, so the FSM is shared by both arbitration modes.

Test Plan:
- Write, then read back: A writes 0x5A to 0x08000 (ack after 1 edge, mem_wren one cycle), then reads 0x08000 -> a_ack after 2 edges, a_rdata=0x5A.
- Contention: a_req and b_req high in the same cycle (B read of 0x00010 holding 0x33) -> B served first, b_rdata=0x33; A served next transaction; no overlapping acks.
- Starvation: b_req permanently high and a_req high, STARVE_MAX=4 -> A granted on the 5th contested decision; count clears afterwards.
- Latency sweep: RD_LATENCY=3 read -> ack after edge N+4 with the correct byte.
- Reset mid-read: reset_n low during WAIT -> mem_wren=0, acks=0, busy=0 immediately. After release, a fresh A read completes normally.
- MEM_ARB_RR_EN: both reqs held high continuously -> grants alternate A,B,A,B starting with B (last-grant reset to A).
